// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and datapath width.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_op_t;

endpackage

// File: rtl/alu_32_comb.sv
// Combinational ALU core: one shared 33-bit adder serves ADD, SUB and SLT.
module alu_32_comb
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_t          op,
  output logic [ALU_W-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  logic             w_sub;
  logic [ALU_W-1:0] w_b_opnd;
  logic [ALU_W:0]   w_sum;
  logic             w_v_add;
  logic             w_v_sub;
  logic [4:0]       w_shamt;

  // SLT reuses the subtract path; its result is sign(a-b) corrected by overflow.
  assign w_sub    = (op == ALU_SUB) || (op == ALU_SLT);
  assign w_b_opnd = w_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_opnd} + {{ALU_W{1'b0}}, w_sub};
  assign w_v_add  = (a[ALU_W-1] == b[ALU_W-1]) && (w_sum[ALU_W-1] != a[ALU_W-1]);
  assign w_v_sub  = (a[ALU_W-1] != b[ALU_W-1]) && (w_sum[ALU_W-1] != a[ALU_W-1]);
  assign w_shamt  = b[4:0];

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        y = w_sum[ALU_W-1:0];
        c = w_sum[ALU_W];
        v = w_v_add;
      end
      ALU_SUB: begin
        y = w_sum[ALU_W-1:0];
        c = w_sum[ALU_W];
        v = w_v_sub;
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(ALU_W-1){1'b0}}, w_sum[ALU_W-1] ^ w_v_sub};
      ALU_SLL: y = a << w_shamt;
      ALU_SRL: y = a >> w_shamt;
      ALU_SRA: y = $signed(a) >>> w_shamt;
      default: y = '0;
    endcase
  end

  assign z = (y == '0);
  assign n = y[ALU_W-1];

endmodule

// File: rtl/alu_32.sv
// 32-bit ALU with registered result and NZCV flags, one cycle of latency.
module alu_32
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_t          op,
  output logic [ALU_W-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  logic [ALU_W-1:0] w_y;
  logic             w_z;
  logic             w_n;
  logic             w_c;
  logic             w_v;

  logic [ALU_W-1:0] r_y;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  alu_32_comb u_comb (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (w_y),
    .z  (w_z),
    .n  (w_n),
    .c  (w_c),
    .v  (w_v)
  );

  // Reset value reports a zero result, so z comes up set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
      r_z <= 1'b1;
      r_n <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_y <= w_y;
      r_z <= w_z;
      r_n <= w_n;
      r_c <= w_c;
      r_v <= w_v;
    end
  end

  assign y = r_y;
  assign z = r_z;
  assign n = r_n;
  assign c = r_c;
  assign v = r_v;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: directed corner cases plus random ops vs. an arithmetic model.
module tb_alu_32;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] y;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op_code = '0;
  alu_op_t     op;
  logic [31:0] y;
  logic        z, n, c, v;

  int checks = 0;
  int failures = 0;

  assign op = alu_op_t'(op_code);

  alu_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .y     (y),
    .z     (z),
    .n     (n),
    .c     (c),
    .v     (v)
  );

  always #5 clk = ~clk;

  // Reference: carry/overflow derived from wide unsigned/signed arithmetic.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [3:0] mop);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    int     sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = longint'({32'b0, ma});
    ub = longint'({32'b0, mb});
    sh = int'(mb & 32'h1F);
    e  = '0;
    case (mop)
      4'd0: begin
        e.y = ma + mb;
        e.c = (ua + ub) > 64'sh0FFFF_FFFF;
        r   = sa + sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd1: begin
        e.y = ma - mb;
        e.c = (ua >= ub);
        r   = sa - sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2: e.y = ma & mb;
      4'd3: e.y = ma | mb;
      4'd4: e.y = ma ^ mb;
      4'd5: e.y = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: e.y = ma << sh;
      4'd7: e.y = ma >> sh;
      4'd8: e.y = 32'($signed(ma) >>> sh);
      default: e.y = '0;
    endcase
    e.z = (e.y == 32'd0);
    e.n = e.y[31];
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    checks++;
    assert (y === e.y) else begin
      failures++;
      $error("FAIL %s y got=%h exp=%h", tag, y, e.y);
    end
    checks++;
    assert (z === e.z) else begin
      failures++;
      $error("FAIL %s z got=%b exp=%b", tag, z, e.z);
    end
    checks++;
    assert (n === e.n) else begin
      failures++;
      $error("FAIL %s n got=%b exp=%b", tag, n, e.n);
    end
    checks++;
    assert (c === e.c) else begin
      failures++;
      $error("FAIL %s c got=%b exp=%b", tag, c, e.c);
    end
    checks++;
    assert (v === e.v) else begin
      failures++;
      $error("FAIL %s v got=%b exp=%b", tag, v, e.v);
    end
  endtask

  // Drive one op, clock it, then compare against the model and an optional fixed y.
  task automatic step(input string tag, input logic [31:0] sa, input logic [31:0] sb,
                      input logic [3:0] sop, input logic chk_y, input logic [31:0] exp_y);
    a       = sa;
    b       = sb;
    op_code = sop;
    @(posedge clk);
    #1;
    check_outputs(tag, model(sa, sb, sop));
    if (chk_y) begin
      checks++;
      assert (y === exp_y) else begin
        failures++;
        $error("FAIL %s fixed y got=%h exp=%h", tag, y, exp_y);
      end
    end
  endtask

  exp_t rst_e;

  initial begin
    rst_e = '{y: 32'd0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0};
    rst_n = 1'b0;
    a = 32'h1234_5678;
    b = 32'h1;
    op_code = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", rst_e);
    rst_n = 1'b1;

    step("add_10_20",   32'd10,         32'd20,         4'd0, 1'b1, 32'd30);
    step("sub_50_8",    32'd50,         32'd8,          4'd1, 1'b1, 32'd42);
    step("sub_5_5",     32'd5,          32'd5,          4'd1, 1'b1, 32'd0);
    step("add_ovf",     32'h7FFF_FFFF,  32'd1,          4'd0, 1'b1, 32'h8000_0000);
    step("add_carry",   32'hFFFF_FFFF,  32'd1,          4'd0, 1'b1, 32'd0);
    step("sub_borrow",  32'd3,          32'd7,          4'd1, 1'b1, 32'hFFFF_FFFC);
    step("sub_ovf",     32'h8000_0000,  32'd1,          4'd1, 1'b1, 32'h7FFF_FFFF);
    step("and",         32'h0000_F0F0,  32'h0000_0FF0,  4'd2, 1'b1, 32'h0000_00F0);
    step("or",          32'h0000_F0F0,  32'h0000_0FF0,  4'd3, 1'b1, 32'h0000_FFF0);
    step("xor",         32'h0000_F0F0,  32'h0000_0FF0,  4'd4, 1'b1, 32'h0000_FF00);
    step("slt_m5_3",    32'hFFFF_FFFB,  32'd3,          4'd5, 1'b1, 32'd1);
    step("slt_3_m5",    32'd3,          32'hFFFF_FFFB,  4'd5, 1'b1, 32'd0);
    step("slt_min_0",   32'h8000_0000,  32'd0,          4'd5, 1'b1, 32'd1);
    step("slt_max_m1",  32'h7FFF_FFFF,  32'hFFFF_FFFF,  4'd5, 1'b1, 32'd0);
    step("sll_31",      32'd1,          32'd31,         4'd6, 1'b1, 32'h8000_0000);
    step("srl_4",       32'h8000_0000,  32'd4,          4'd7, 1'b1, 32'h0800_0000);
    step("sra_4",       32'h8000_0000,  32'd4,          4'd8, 1'b1, 32'hF800_0000);
    step("sll_32",      32'hDEAD_BEEF,  32'h20,         4'd6, 1'b1, 32'hDEAD_BEEF);
    step("sra_hi_b",    32'h8765_4321,  32'hFFFF_FFE0,  4'd8, 1'b1, 32'h8765_4321);
    step("rsvd_9",      32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd9, 1'b1, 32'd0);
    step("rsvd_15",     32'h1234_5678,  32'h1,          4'd15, 1'b1, 32'd0);

    // Mid-stream reset: leave a non-reset result in the register, then assert away from the edge.
    step("pre_rst",     32'hFFFF_FFFF,  32'd0,          4'd3, 1'b1, 32'hFFFF_FFFF);
    a = 32'h7FFF_FFFF;
    b = 32'd1;
    op_code = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", rst_e);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", rst_e);
    rst_n = 1'b1;
    step("post_rst",    32'd10,         32'd20,         4'd0, 1'b1, 32'd30);

    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 15));
      if (i % 4 == 0) rb = rb & 32'h0000_003F;
      if (i % 7 == 0) ra = ra | 32'h8000_0000;
      step($sformatf("rand%0d_op%0d", i, rop), ra, rb, rop, 1'b0, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
